apu_frame_counter: RTL

- Drives the APU sequencer, i.e. produces the `qtrframe` and `halfframe` strobes consumed by the triangle, pulse, noise and length units.
- Handles CPU writes to $4017:
  - mode select: 4-step or 5-step sequence
  - IRQ inhibit
  - delayed sequence reset
- Generates the frame IRQ flag, which is cleared by a $4015 read.
- Sits in the APU top beside the channel blocks and is advanced by the CPU-cycle enable.

---
 rtl/apu_frame_counter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/apu_frame_counter.sv
`timescale 1ns/1ps
// APU frame counter: sequences quarter/half-frame strobes, handles $4017 writes and the frame IRQ.
// Latency: strobes and IRQ are registered, visible one clk after the ce cycle whose cnt matched.
// Backpressure: none; all state advances only on ce, strobes are 0 on clocks without ce.
module apu_frame_counter #(
  parameter int STEP1    = 7457,
  parameter int STEP2    = 14913,
  parameter int STEP3    = 22371,
  parameter int STEP4    = 29829,
  parameter int STEP5    = 37281,
  parameter int DLY_EVEN = 3,
  parameter int DLY_ODD  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       wr_4017,
  input  logic [7:0] wdata,
  input  logic       status_read,
  output logic       qtrframe,
  output logic       halfframe,
  output logic       frame_irq,
  output logic       mode
);

  // Counter must hold the 5-step final value, which does not fit in 15 bits.
  localparam int CW = $clog2(STEP5 + 1);

  localparam logic [CW-1:0] C_STEP1   = CW'(STEP1);
  localparam logic [CW-1:0] C_STEP2   = CW'(STEP2);
  localparam logic [CW-1:0] C_STEP3   = CW'(STEP3);
  localparam logic [CW-1:0] C_STEP4   = CW'(STEP4);
  localparam logic [CW-1:0] C_STEP4M1 = CW'(STEP4 - 1);
  localparam logic [CW-1:0] C_STEP5   = CW'(STEP5);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [2:0]    C_DEVEN   = 3'(DLY_EVEN);
  localparam logic [2:0]    C_DODD    = 3'(DLY_ODD);

  logic [CW-1:0] cnt;
  logic          inhibit;
  logic          parity;
  logic          pend;
  logic [2:0]    dly;
  logic          wrapped;

  logic          hit1, hit2, hit3, hit4, hit5;
  logic          hit_last;
  logic          q_cnt, h_cnt;
  logic          irq_set;
  logic          fire;

  // Only the mode and inhibit bits of the write data are meaningful here.
  logic          unused_wdata;
  assign unused_wdata = ^wdata[5:0];

  // Decode step matches, strobe requests, IRQ set condition and the delayed-reset event.
  always_comb begin
    hit1     = (cnt == C_STEP1);
    hit2     = (cnt == C_STEP2);
    hit3     = (cnt == C_STEP3);
    hit4     = (cnt == C_STEP4);
    hit5     = (cnt == C_STEP5);
    hit_last = mode ? hit5 : hit4;
    q_cnt    = hit1 | hit2 | hit3 | hit_last;
    h_cnt    = hit2 | hit_last;
    irq_set  = ~mode & ~inhibit & ((cnt == C_STEP4M1) | hit4 | ((cnt == '0) & wrapped));
    // A write on the same ce restarts the delay, so it suppresses the reset event.
    fire     = ce & ~wr_4017 & pend & (dly == 3'd1);
  end

  // Sequencer state: counter, parity, $4017 latches and the pending-reset countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      mode    <= 1'b0;
      inhibit <= 1'b0;
      parity  <= 1'b0;
      pend    <= 1'b0;
      dly     <= 3'd0;
      wrapped <= 1'b0;
    end else if (ce) begin
      parity  <= ~parity;
      cnt     <= hit_last ? '0 : cnt + C_ONE;
      wrapped <= ~mode & hit4;
      if (wr_4017) begin
        mode    <= wdata[7];
        inhibit <= wdata[6];
        pend    <= 1'b1;
        dly     <= parity ? C_DODD : C_DEVEN;
      end else if (pend) begin
        dly <= dly - 3'd1;
        if (fire) begin
          pend    <= 1'b0;
          cnt     <= '0;
          wrapped <= 1'b0;
        end
      end
    end
  end

  // Registered strobes and the level frame IRQ; an inhibit write beats a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qtrframe  <= 1'b0;
      halfframe <= 1'b0;
      frame_irq <= 1'b0;
    end else begin
      qtrframe  <= ce & (q_cnt | (fire & mode));
      halfframe <= ce & (h_cnt | (fire & mode));
      if (ce) begin
        if (wr_4017 && wdata[6]) begin
          frame_irq <= 1'b0;
        end else if (irq_set) begin
          frame_irq <= 1'b1;
        end else if (status_read) begin
          frame_irq <= 1'b0;
        end
      end
    end
  end

endmodule
